// File: rtl/xor_ann_seq.sv
// xor_ann_seq: time-multiplexed 2-2-1 step-activation network (XOR by default) on one shared accumulator.
// Optional build macro XOR_ANN_SEQ_SUM_EN exposes the Y pre-activation sum on port y_sum.
module xor_ann_seq #(
  parameter int WIDTH = 8,
  parameter int W_H1A = 2,
  parameter int W_H1B = 2,
  parameter int B_H1  = -1,
  parameter int W_H2A = -2,
  parameter int W_H2B = -2,
  parameter int B_H2  = 3,
  parameter int W_YH1 = 2,
  parameter int W_YH2 = 2,
  parameter int B_Y   = -3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic a,
  input  logic b,
  output logic out_valid,
  input  logic out_ready,
  output logic y,
  output logic h1,
  output logic h2,
`ifdef XOR_ANN_SEQ_SUM_EN
  output logic signed [WIDTH+1:0] y_sum,
`endif
  output logic busy
);

  localparam int ACC_W = WIDTH + 2;

  localparam logic signed [WIDTH-1:0] K_H1A = WIDTH'(W_H1A);
  localparam logic signed [WIDTH-1:0] K_H1B = WIDTH'(W_H1B);
  localparam logic signed [WIDTH-1:0] K_BH1 = WIDTH'(B_H1);
  localparam logic signed [WIDTH-1:0] K_H2A = WIDTH'(W_H2A);
  localparam logic signed [WIDTH-1:0] K_H2B = WIDTH'(W_H2B);
  localparam logic signed [WIDTH-1:0] K_BH2 = WIDTH'(B_H2);
  localparam logic signed [WIDTH-1:0] K_YH1 = WIDTH'(W_YH1);
  localparam logic signed [WIDTH-1:0] K_YH2 = WIDTH'(W_YH2);
  localparam logic signed [WIDTH-1:0] K_BY  = WIDTH'(B_Y);

  typedef enum logic [2:0] {IDLE, N_H1, N_H2, N_Y, DONE} state_t;

  state_t state, state_nxt;
  logic [1:0] step;
  logic a_r, b_r;
  logic signed [ACC_W-1:0] acc, acc_nxt, term;
  logic signed [WIDTH-1:0] bias, w0, w1;
  logic x0, x1;
  logic accept, in_neuron, last_step;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [WIDTH-1:0] v);
    return {{(ACC_W-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  // Strict step activation: only a positive sum fires.
  function automatic logic fire(input logic signed [ACC_W-1:0] s);
    return !s[ACC_W-1] && (s != '0);
  endfunction

  assign accept    = (state == IDLE) && in_valid;
  assign in_neuron = (state == N_H1) || (state == N_H2) || (state == N_Y);
  assign last_step = in_neuron && (step == 2'd2);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    bias = '0;
    w0   = '0;
    w1   = '0;
    x0   = 1'b0;
    x1   = 1'b0;
    unique case (state)
      N_H1: begin bias = K_BH1; w0 = K_H1A; w1 = K_H1B; x0 = a_r; x1 = b_r; end
      N_H2: begin bias = K_BH2; w0 = K_H2A; w1 = K_H2B; x0 = a_r; x1 = b_r; end
      N_Y:  begin bias = K_BY;  w0 = K_YH1; w1 = K_YH2; x0 = h1;  x1 = h2;  end
      default: ;
    endcase
    term = '0;
    if ((step == 2'd1) && x0) begin
      term = sext(w0);
    end else if ((step == 2'd2) && x1) begin
      term = sext(w1);
    end
    acc_nxt = acc + term;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)       state_nxt = N_H1;
      N_H1:    if (step == 2'd2)   state_nxt = N_H2;
      N_H2:    if (step == 2'd2)   state_nxt = N_Y;
      N_Y:     if (step == 2'd2)   state_nxt = DONE;
      DONE:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step  <= 2'd0;
      acc   <= '0;
      a_r   <= 1'b0;
      b_r   <= 1'b0;
      h1    <= 1'b0;
      h2    <= 1'b0;
      y     <= 1'b0;
`ifdef XOR_ANN_SEQ_SUM_EN
      y_sum <= '0;
`endif
    end else begin
      step <= (in_neuron && (step != 2'd2)) ? step + 2'd1 : 2'd0;
      if (accept) begin
        a_r <= a;
        b_r <= b;
        h1  <= 1'b0;
        h2  <= 1'b0;
        y   <= 1'b0;
      end
      if (in_neuron) begin
        acc <= (step == 2'd0) ? sext(bias) : acc_nxt;
      end
      // The neuron register takes the final sum in the same edge as the accumulator.
      if (last_step) begin
        if (state == N_H1) h1 <= fire(acc_nxt);
        if (state == N_H2) h2 <= fire(acc_nxt);
        if (state == N_Y) begin
          y <= fire(acc_nxt);
`ifdef XOR_ANN_SEQ_SUM_EN
          y_sum <= acc_nxt;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_xor_ann_seq.sv
// Bench for xor_ann_seq: default XOR build plus an OR-reprogrammed and a zero-sum-boundary instance.
module tb_xor_ann_seq;
  localparam int WIDTH = 8;
  localparam int ACC_W = WIDTH + 2;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, a = 1'b0, b = 1'b0;
  logic in_ready, out_valid, y, h1, h2, busy;
  logic in_ready2, out_valid2, y2, h1_2, h2_2, busy2;
  logic in_ready3, out_valid3, y3, h1_3, h2_3, busy3;
`ifdef XOR_ANN_SEQ_SUM_EN
  logic signed [ACC_W-1:0] y_sum, y_sum2, y_sum3;
`endif

  always #5 clk = ~clk;

  xor_ann_seq dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y), .h1(h1), .h2(h2),
`ifdef XOR_ANN_SEQ_SUM_EN
    .y_sum(y_sum),
`endif
    .busy(busy));

  xor_ann_seq #(.W_H2A(0), .W_H2B(0), .B_H2(1)) dut2 (.clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b), .out_valid(out_valid2),
    .out_ready(out_ready), .y(y2), .h1(h1_2), .h2(h2_2),
`ifdef XOR_ANN_SEQ_SUM_EN
    .y_sum(y_sum2),
`endif
    .busy(busy2));

  xor_ann_seq #(.B_H1(0)) dut3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(in_ready3), .a(a), .b(b), .out_valid(out_valid3), .out_ready(out_ready),
    .y(y3), .h1(h1_3), .h2(h2_3),
`ifdef XOR_ANN_SEQ_SUM_EN
    .y_sum(y_sum3),
`endif
    .busy(busy3));

  // y2/h2b: OR-reprogrammed instance; h1c/yc: instance whose H1 sum hits exactly 0 for 00.
  typedef struct {
    logic a, b, h1, h2, y;
    int   ysum;
    logic y2, h2b, h1c, yc;
  } vec_t;

  vec_t tbl[4];
  vec_t sbq[$];
  vec_t mon_e;
  int total = 0, bad = 0, pushes = 0, pops = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic sa, input logic sb);
    @(posedge clk); #1;
    a = sa; b = sb; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(tbl[{sa, sb}]);
        pushes++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    total++; bad++;
    $display("FAIL send_timeout: in_ready=%0d, expected 1", in_ready);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sbq.size() == 0) return;
    end
    total++; bad++;
    $display("FAIL drain_timeout: queue depth %0d, expected 0", sbq.size());
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: y=%0d with no sample pending", y);
      end else begin
        mon_e = sbq.pop_front();
        pops++;
        chk("h1", h1, mon_e.h1);
        chk("h2", h2, mon_e.h2);
        chk("y", y, mon_e.y);
        chk("or_valid", out_valid2, 1);
        chk("or_h1", h1_2, mon_e.h1);
        chk("or_h2", h2_2, mon_e.h2b);
        chk("or_y", y2, mon_e.y2);
        chk("zb_valid", out_valid3, 1);
        chk("zb_h1", h1_3, mon_e.h1c);
        chk("zb_h2", h2_3, mon_e.h2);
        chk("zb_y", y3, mon_e.yc);
`ifdef XOR_ANN_SEQ_SUM_EN
        chk("y_sum", y_sum, mon_e.ysum);
        chk("or_y_sum", y_sum2, mon_e.y2 ? 1 : -1);
        chk("zb_y_sum", y_sum3, mon_e.ysum);
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state of every instance
    #12;
    chk("rst_in_ready", in_ready, 1);  chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);          chk("rst_y", y, 0);
    chk("rst_h1", h1, 0);              chk("rst_h2", h2, 0);
    chk("rst_in_ready2", in_ready2, 1); chk("rst_out_valid2", out_valid2, 0);
    chk("rst_busy2", busy2, 0);        chk("rst_y2", y2, 0);
    chk("rst_h1_2", h1_2, 0);          chk("rst_h2_2", h2_2, 0);
    chk("rst_in_ready3", in_ready3, 1); chk("rst_out_valid3", out_valid3, 0);
    chk("rst_busy3", busy3, 0);        chk("rst_y3", y3, 0);
    chk("rst_h1_3", h1_3, 0);          chk("rst_h2_3", h2_3, 0);
`ifdef XOR_ANN_SEQ_SUM_EN
    chk("rst_y_sum", y_sum, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Truth table across all three parameter sets
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].a, tbl[i].b);
      drain();
    end

    // Latency: accept at E0, result at E9, next accept at E11
    @(posedge clk); #1;
    a = 1'b0; b = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("lat_ready_e0", in_ready, 1);
    sbq.push_back(tbl[1]); pushes++;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      chk("lat_out_valid", out_valid, (k == 9) ? 1 : 0);
      chk("lat_in_ready", in_ready, (k >= 10) ? 1 : 0);
    end
    sbq.push_back(tbl[1]); pushes++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Backpressure: result held, extra in_valid pulses ignored
    out_ready = 1'b0;
    send(1'b1, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("bp_reached_done", out_valid, 1);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      in_valid = (k % 2 == 1); a = 1'b1; b = 1'b1;
      @(negedge clk);
      chk("bp_valid", out_valid, 1); chk("bp_y", y, 1);
      chk("bp_busy", busy, 1);       chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_queue", sbq.size(), 0);

    // Input stability: a/b wiggle after capture
    send(1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      a = (k % 3 == 0); b = (k % 2 == 0);
      @(posedge clk); #1;
    end
    a = 1'b0; b = 1'b0;
    drain();

    // Reset mid-evaluation
    send(1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_pre_h1", h1, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0); chk("mid_y", y, 0);
    chk("mid_h1", h1, 0);               chk("mid_h2", h2, 0);
    chk("mid_in_ready", in_ready, 1);   chk("mid_busy", busy, 0);
    pushes -= sbq.size();
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1, 1'b1);
    drain();

    chk("sb_empty", sbq.size(), 0);
    chk("sb_count", pops, pushes);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
